// File: rtl/ddr4_arb_pkg.sv
// Shared types and constants for the DDR4 EMIF two-requester arbiter.
// Holds the FSM state enum, the read-tag record and the counter helper.
package ddr4_arb_pkg;

  localparam int TAG_BC_W = 7;

  localparam logic [1:0] STATUS_WAIT  = 2'b00;
  localparam logic [1:0] STATUS_READY = 2'b01;
  localparam logic [1:0] STATUS_ERROR = 2'b10;

  typedef enum logic [1:0] {
    ST_WAIT_CAL,
    ST_IDLE,
    ST_WR_BURST,
    ST_ERROR
  } arb_state_t;

  typedef struct packed {
    logic                id;
    logic [TAG_BC_W-1:0] burstcount;
  } tag_t;

  // Saturating add so long-running counters pin at all-ones instead of wrapping.
  function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/ddr4_arb_tag_fifo.sv
// Outstanding read-burst tag FIFO: one entry per accepted read command.
// Push and pop may coincide; full/empty reflect the registered occupancy.
module ddr4_arb_tag_fifo
  import ddr4_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_push,
  input  tag_t i_pushTag,
  input  logic i_pop,
  output tag_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  tag_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign o_head   = r_mem[r_rdPtr];

  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushTag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ddr4_emif_arbiter.sv
// Round-robin Avalon-MM arbiter sharing one DDR4 EMIF user port between two requesters.
// Optional performance counters are enabled with the DDR4_ARB_PERF_EN macro.
module ddr4_emif_arbiter
  import ddr4_arb_pkg::*;
#(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 512,
  parameter int BE_W      = DATA_W / 8,
  parameter int BURST_W   = 7,
  parameter int TAG_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cal_success,
  input  logic               cal_fail,
  output logic [1:0]         status,

  input  logic [ADDR_W-1:0]  m0_address,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BE_W-1:0]    m0_byteenable,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,

  input  logic [ADDR_W-1:0]  m1_address,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BE_W-1:0]    m1_byteenable,
  input  logic [BURST_W-1:0] m1_burstcount,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,

  output logic [ADDR_W-1:0]  emif_address,
  output logic               emif_read,
  output logic               emif_write,
  output logic [DATA_W-1:0]  emif_writedata,
  output logic [BE_W-1:0]    emif_byteenable,
  output logic [BURST_W-1:0] emif_burstcount,
  input  logic               emif_waitrequest,
  input  logic [DATA_W-1:0]  emif_readdata,
  input  logic               emif_readdatavalid,

  output logic [31:0]        perf_beats0,
  output logic [31:0]        perf_beats1,
  output logic [31:0]        perf_stall0,
  output logic [31:0]        perf_stall1
);

  arb_state_t         r_state;
  arb_state_t         w_nextState;
  logic               r_rr;
  logic               r_owner;
  logic [BURST_W-1:0] r_remaining;
  logic [BURST_W-1:0] r_headBeat;

  logic               w_elig0;
  logic               w_elig1;
  logic               w_gntValid;
  logic               w_gntId;
  logic               w_selRead;
  logic [BURST_W-1:0] w_selBurst;
  logic               w_accept;
  logic               w_burstStart;
  logic               w_burstEnd;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  tag_t               w_pushTag;
  tag_t               w_head;
  logic               w_rdvHit;
  logic               w_lastBeat;
  logic               w_protoErr;

  // A read only competes while a tag slot is free; read wins over a simultaneous write.
  always_comb begin
    w_elig0    = m0_read ? ~w_full : m0_write;
    w_elig1    = m1_read ? ~w_full : m1_write;
    w_gntValid = 1'b0;
    w_gntId    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig0 && (!r_rr || !w_elig1)) begin
          w_gntValid = 1'b1;
          w_gntId    = 1'b0;
        end else if (w_elig1) begin
          w_gntValid = 1'b1;
          w_gntId    = 1'b1;
        end
      end
      ST_WR_BURST: begin
        w_gntId    = r_owner;
        w_gntValid = r_owner ? m1_write : m0_write;
      end
      default: begin
        w_gntValid = 1'b0;
      end
    endcase
  end

  assign w_selRead  = (r_state == ST_IDLE) && (w_gntId ? m1_read : m0_read);
  assign w_selBurst = w_gntId ? m1_burstcount : m0_burstcount;

  assign emif_address    = w_gntId ? m1_address    : m0_address;
  assign emif_writedata  = w_gntId ? m1_writedata  : m0_writedata;
  assign emif_byteenable = w_gntId ? m1_byteenable : m0_byteenable;
  assign emif_burstcount = w_selBurst;
  assign emif_read       = w_gntValid & w_selRead;
  assign emif_write      = w_gntValid & ~w_selRead;

  assign m0_waitrequest = (w_gntValid && !w_gntId) ? emif_waitrequest : 1'b1;
  assign m1_waitrequest = (w_gntValid &&  w_gntId) ? emif_waitrequest : 1'b1;

  assign w_accept     = w_gntValid & ~emif_waitrequest;
  assign w_burstStart = w_accept && (r_state == ST_IDLE) && !w_selRead
                        && (w_selBurst > BURST_W'(1));
  assign w_burstEnd   = w_accept && (r_state == ST_WR_BURST)
                        && (r_remaining == BURST_W'(1));

  always_comb begin
    w_pushTag.id         = w_gntId;
    w_pushTag.burstcount = TAG_BC_W'((w_selBurst == '0) ? BURST_W'(1) : w_selBurst);
  end
  assign w_push = w_accept & w_selRead;

  ddr4_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tagFifo (
    .clock     (clock),
    .reset     (reset),
    .i_push    (w_push),
    .i_pushTag (w_pushTag),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Returning beats belong to the oldest outstanding burst; data itself is broadcast.
  assign w_rdvHit   = emif_readdatavalid & ~w_empty;
  assign w_protoErr = emif_readdatavalid & w_empty;
  assign w_lastBeat = ((r_headBeat + BURST_W'(1)) == BURST_W'(w_head.burstcount));
  assign w_pop      = w_rdvHit & w_lastBeat;

  assign m0_readdatavalid = w_rdvHit & ~w_head.id;
  assign m1_readdatavalid = w_rdvHit &  w_head.id;
  assign m0_readdata      = emif_readdata;
  assign m1_readdata      = emif_readdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_WAIT_CAL;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    status      = STATUS_WAIT;
    case (r_state)
      ST_WAIT_CAL: begin
        if (cal_fail || w_protoErr) begin
          w_nextState = ST_ERROR;
        end else if (cal_success) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_IDLE: begin
        status = STATUS_READY;
        if (cal_fail || w_protoErr) begin
          w_nextState = ST_ERROR;
        end else if (w_burstStart) begin
          w_nextState = ST_WR_BURST;
        end
      end
      ST_WR_BURST: begin
        status = STATUS_READY;
        if (cal_fail || w_protoErr) begin
          w_nextState = ST_ERROR;
        end else if (w_burstEnd) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_ERROR: begin
        status = STATUS_ERROR;
      end
      default: begin
        w_nextState = ST_WAIT_CAL;
      end
    endcase
  end

  // The RR pointer holds through a write burst and only passes on once the burst ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr        <= 1'b0;
      r_owner     <= 1'b0;
      r_remaining <= '0;
      r_headBeat  <= '0;
    end else begin
      if (w_accept) begin
        if (r_state == ST_WR_BURST) begin
          r_remaining <= r_remaining - BURST_W'(1);
          if (w_burstEnd) begin
            r_rr <= ~r_owner;
          end
        end else if (w_burstStart) begin
          r_owner     <= w_gntId;
          r_remaining <= w_selBurst - BURST_W'(1);
        end else begin
          r_rr <= ~w_gntId;
        end
      end
      if (w_pop) begin
        r_headBeat <= '0;
      end else if (w_rdvHit) begin
        r_headBeat <= r_headBeat + BURST_W'(1);
      end
    end
  end

`ifdef DDR4_ARB_PERF_EN
  logic [31:0] r_beats0;
  logic [31:0] r_beats1;
  logic [31:0] r_stall0;
  logic [31:0] r_stall1;
  logic [1:0]  w_beatInc0;
  logic [1:0]  w_beatInc1;

  // A requester can see a command beat accepted and a read beat returned in one cycle.
  assign w_beatInc0 = {1'b0, w_accept & ~w_gntId} + {1'b0, m0_readdatavalid};
  assign w_beatInc1 = {1'b0, w_accept &  w_gntId} + {1'b0, m1_readdatavalid};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_beats0 <= '0;
      r_beats1 <= '0;
      r_stall0 <= '0;
      r_stall1 <= '0;
    end else begin
      r_beats0 <= satAdd(r_beats0, w_beatInc0);
      r_beats1 <= satAdd(r_beats1, w_beatInc1);
      r_stall0 <= satAdd(r_stall0, {1'b0, (m0_read | m0_write) & m0_waitrequest});
      r_stall1 <= satAdd(r_stall1, {1'b0, (m1_read | m1_write) & m1_waitrequest});
    end
  end

  assign perf_beats0 = r_beats0;
  assign perf_beats1 = r_beats1;
  assign perf_stall0 = r_stall0;
  assign perf_stall1 = r_stall1;
`else
  assign perf_beats0 = '0;
  assign perf_beats1 = '0;
  assign perf_stall0 = '0;
  assign perf_stall1 = '0;
`endif

endmodule

// File: doc/ddr4_emif_arbiter.md
Name: ddr4_emif_arbiter

Overview:
Two-requester Avalon-MM arbiter that shares the single DDR4-C EMIF user port between the SIMT core memory subsystem (requester 0) and the host/debug DMA path (requester 1). It gates all traffic until EMIF calibration succeeds. It arbitrates round-robin at command granularity and locks the grant for the full length of a write burst. It tracks outstanding read bursts so that returning read data is routed to the requester that issued the command.

Parameters:
ADDR_W, 26, word address width of EMIF user port
DATA_W, 512, data width
BE_W, DATA_W/8, byte-enable width
BURST_W, 7, burstcount width (max burst 64)
TAG_DEPTH, 8, max outstanding read bursts (power of two)

Ports:
clock  in  1  single clock (EMIF user clock)
reset  in  1  synchronous, active-high reset
cal_success  in  1  EMIF local_cal_success
cal_fail  in  1  EMIF local_cal_fail
status  out  2  {error, ready}
mN_address  in  ADDR_W  requester N address (N = 0,1; all mN_ ports are duplicated per requester)
mN_read / mN_write  in  1  command strobes
mN_writedata  in  DATA_W
mN_byteenable  in  BE_W
mN_burstcount  in  BURST_W
mN_waitrequest  out  1
mN_readdata  out  DATA_W
mN_readdatavalid  out  1
emif_address/read/write/writedata/byteenable/burstcount  out  —  forwarded command to EMIF
emif_waitrequest  in  1
emif_readdata  in  DATA_W
emif_readdatavalid  in  1
perf_beats0, perf_beats1, perf_stall0, perf_stall1  out  32 each  performance counters

Behaviour:
- FSM states: WAIT_CAL, IDLE, WR_BURST, ERROR. Reset enters WAIT_CAL.
- Reset values: status=0; mN_waitrequest=1; mN_readdatavalid=0; emif_read=emif_write=0; tag FIFO empty; RR pointer=0; beat counters=0.
- WAIT_CAL: on cal_success=1, go to IDLE and set ready. If cal_fail=1, go to ERROR. cal_fail takes priority when both are asserted.
- ERROR: sticky until reset. status=2'b10, all waitrequests held at 1, no EMIF commands issued.
- IDLE grant:
  - Combinational, zero latency. Among requesters with read|write asserted, choose the one favoured by the RR pointer.
  - A read is eligible only if the tag FIFO is not full. An ineligible read is skipped, and the other requester may win.
  - The granted requester's command is driven onto emif_*. Its mN_waitrequest = emif_waitrequest; the loser's waitrequest = 1.
- Command acceptance: granted & !emif_waitrequest. On acceptance the RR pointer moves to the other requester.
- Read accept: push {id, burstcount} into the tag FIFO. A burstcount of 0 is treated as 1.
- Write accept:
  - burstcount>1: go to WR_BURST, latch the owner, and set remaining = burstcount-1.
  - WR_BURST: only the owner is granted. remaining decrements on each accepted beat; return to IDLE when the final beat is accepted.
  - The RR pointer updates when the burst completes.
- Read return:
  - emif_readdatavalid is steered to the FIFO-head id in the same cycle; readdata is broadcast to both requesters.
  - A head beat counter increments per beat. Pop on the final beat of the burst and clear the counter.
- Push and pop in the same cycle are legal. Full is evaluated before the pop, so no push occurs while full.
- emif_readdatavalid while the FIFO is empty is a protocol error: the beat is dropped and ERROR is entered.
- Reset mid-operation discards in-flight bookkeeping. EMIF is reset by the same source, so stale returns are not expected.
- Both mN_read and mN_write asserted together: read wins.

Optional Feature:
DDR4_ARB_PERF_EN:
- Defined: perf_beatsN counts accepted command beats plus returned read beats per requester. perf_stallN counts cycles where mN_read|mN_write=1 and mN_waitrequest=1. Counters are cleared by reset and saturate at 2^32-1.
- Undefined: counter logic is omitted and the perf_* ports are tied to 0.

Decomposition:
- Package ddr4_arb_pkg: state enum, tag struct {id, burstcount}, constants STATUS_READY, STATUS_ERROR.
- Sub-module ddr4_arb_tag_fifo: synchronous FIFO of TAG_DEPTH tags with full/empty, supporting push and pop in the same cycle.

Test Plan:
- cal_success held low 100 cycles while m0 issues a read -> m0_waitrequest=1 throughout, no emif_read. Raise cal_success -> read forwarded the next cycle, status=01.
- m0 and m1 both issue 1-beat reads continuously, emif_waitrequest=0 -> grants alternate 0,1,0,1. readdatavalid is routed in issue order; with 8 returns, 4 go to each requester.
- m0 write burstcount=4 while m1 requests a read -> m1 is stalled for exactly the 4 accepted m0 beats (including injected emif_waitrequest cycles), then m1 is granted.
- Issue 8 read bursts of 2 with no returns -> FIFO full. A 9th read stalls while an m1 write is still granted. One completed return burst unblocks the 9th read.
- cal_fail pulse in IDLE -> status=10, all waitrequests=1 until reset. After reset, status=00.
- With DDR4_ARB_PERF_EN: m1 stalls for 5 cycles then sends a 3-beat write -> perf_stall1=5, perf_beats1=3.
